lsu_data_ram: RTL



---
 rtl/lsu_data_ram_pkg.sv | 20 ++
 rtl/dmem_load_align.sv | 34 +++
 rtl/lsu_data_ram.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/lsu_data_ram_pkg.sv
// Shared constants for the rooth data memory: access size encodings and FSM states.
package lsu_data_ram_pkg;

   localparam logic [1:0] DMEM_SIZE_B = 2'b00;
   localparam logic [1:0] DMEM_SIZE_H = 2'b01;
   localparam logic [1:0] DMEM_SIZE_W = 2'b10;
   localparam logic [1:0] DMEM_SIZE_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_WAIT = 2'd1,
      ST_RESP = 2'd2
   } state_e;

   // Number of bytes touched by an access of the given size encoding.
   function automatic logic [3:0] size_bytes(input logic [1:0] size);
      return 4'(4'd1 << size);
   endfunction

endpackage

// File: rtl/dmem_load_align.sv
// Load alignment: shifts the addressed bytes down, truncates to the access size
// and sign- or zero-extends. Purely combinational; shared with the cache data path.
module dmem_load_align
   import lsu_data_ram_pkg::*;
#(
   parameter int unsigned DATA_W = 32
) (
   input  logic [DATA_W-1:0]            word,
   input  logic [$clog2(DATA_W/8)-1:0]  offset,
   input  logic [1:0]                   size,
   input  logic                         uns,
   output logic [DATA_W-1:0]            result
);

   logic [DATA_W-1:0] shifted;
   logic [DATA_W-1:0] mask;
   logic [DATA_W-1:0] msb;
   logic              sign;

   // Extract, truncate and extend; the sign bit is found via the top bit of the size mask.
   always_comb begin
      shifted = word >> {offset, 3'b000};
      case (size)
         DMEM_SIZE_B: mask = DATA_W'(8'hFF);
         DMEM_SIZE_H: mask = DATA_W'(16'hFFFF);
         DMEM_SIZE_W: mask = DATA_W'(32'hFFFF_FFFF);
         default:     mask = '1;
      endcase
      msb    = mask & ~(mask >> 1);
      sign   = !uns && (|(shifted & msb));
      result = (shifted & mask) | ({DATA_W{sign}} & ~mask);
   end

endmodule

// File: rtl/lsu_data_ram.sv
// Handshaked data memory for the rooth load/store path: registered read, byte-lane
// stores, extended sub-word loads, 1- or 2-cycle read latency, one request in flight.
// Optional: define LSU_DATA_RAM_MISALIGN_CHECK_EN to flag misaligned accesses as
// errors; otherwise misaligned accesses are aligned down.
module lsu_data_ram
   import lsu_data_ram_pkg::*;
#(
   parameter int unsigned DATA_W = 32,
   parameter int unsigned DEPTH  = 1024,
   parameter int unsigned ADDR_W = 32,
   parameter int unsigned RD_LAT = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic              req_we_i,
   input  logic [ADDR_W-1:0] req_addr_i,
   input  logic [1:0]        req_size_i,
   input  logic              req_unsigned_i,
   input  logic [DATA_W-1:0] req_wdata_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [DATA_W-1:0] rsp_rdata_o,
   output logic              rsp_err_o
);

   localparam int unsigned BYTES = DATA_W / 8;
   localparam int unsigned OFF_W = $clog2(BYTES);
   localparam int unsigned IDX_W = $clog2(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];

   state_e            state;
   logic [IDX_W-1:0]  idx;
   logic [OFF_W-1:0]  off_raw;
   logic [OFF_W-1:0]  lo_mask;
   logic [OFF_W-1:0]  off;
   logic              size_ok;
   logic              err;
   logic              accept;
   logic [BYTES-1:0]  strb;
   logic [DATA_W-1:0] wdata_sh;
   logic [DATA_W-1:0] word_q;
   logic [DATA_W-1:0] aligned;
   logic [OFF_W-1:0]  off_q;
   logic [1:0]        size_q;
   logic              uns_q;
   logic              load_q;
   logic              err_q;
   logic              unused_addr_hi;

   assign req_ready_o    = (state == ST_IDLE) && !rst;
   assign accept         = req_valid_i && req_ready_o;
   assign idx            = req_addr_i[IDX_W+OFF_W-1:OFF_W];
   assign off_raw        = req_addr_i[OFF_W-1:0];
   assign unused_addr_hi = ^req_addr_i[ADDR_W-1:IDX_W+OFF_W];

   // Request decode: legality, effective offset, lane strobes and shifted store data.
   always_comb begin
      size_ok = (req_size_i != DMEM_SIZE_D) || (DATA_W == 64);
      lo_mask = OFF_W'(size_bytes(req_size_i) - 4'd1);
`ifdef LSU_DATA_RAM_MISALIGN_CHECK_EN
      err     = !size_ok || (|(off_raw & lo_mask));
      off     = off_raw;
`else
      err     = !size_ok;
      off     = off_raw & ~lo_mask;
`endif
      strb     = BYTES'((16'd1 << size_bytes(req_size_i)) - 16'd1) << off;
      wdata_sh = req_wdata_i << {off, 3'b000};
   end

   // Array: strobed byte writes and registered read, both at the accept edge; never reset.
   always_ff @(posedge clk) begin
      if (accept) begin
         word_q <= mem[idx];
         if (req_we_i && !err) begin
            for (int unsigned b = 0; b < BYTES; b++) begin
               if (strb[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
            end
         end
      end
   end

   // Control FSM with registered response flags and captured load attributes.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         rsp_valid_o <= 1'b0;
         rsp_err_o   <= 1'b0;
         err_q       <= 1'b0;
         load_q      <= 1'b0;
         uns_q       <= 1'b0;
         size_q      <= DMEM_SIZE_B;
         off_q       <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  off_q  <= off;
                  size_q <= req_size_i;
                  uns_q  <= req_unsigned_i;
                  load_q <= !req_we_i;
                  err_q  <= err;
                  if (RD_LAT == 1) begin
                     state       <= ST_RESP;
                     rsp_valid_o <= 1'b1;
                     rsp_err_o   <= err;
                  end else begin
                     state <= ST_WAIT;
                  end
               end
            end
            ST_WAIT: begin
               state       <= ST_RESP;
               rsp_valid_o <= 1'b1;
               rsp_err_o   <= err_q;
            end
            ST_RESP: begin
               if (rsp_ready_i) begin
                  state       <= ST_IDLE;
                  rsp_valid_o <= 1'b0;
                  rsp_err_o   <= 1'b0;
               end
            end
            default: begin
               state       <= ST_IDLE;
               rsp_valid_o <= 1'b0;
               rsp_err_o   <= 1'b0;
            end
         endcase
      end
   end

   dmem_load_align #(
      .DATA_W (DATA_W)
   ) u_align (
      .word   (word_q),
      .offset (off_q),
      .size   (size_q),
      .uns    (uns_q),
      .result (aligned)
   );

   // Response data is zero for stores, errors and whenever no response is pending.
   assign rsp_rdata_o = (rsp_valid_o && load_q && !rsp_err_o) ? aligned : '0;

endmodule
